multiword_add_seq: RTL and testbench

- Sequential multi-precision adder that streams two WORDS×WIDTH-bit operands one WIDTH-bit word pair per beat, least-significant word first.
- Chains the carry between beats through a register around one combinational nbitAdd instance.
- Produces a registered stream of sum words plus the final carry-out.
- Sits directly around the team's n-bit adder: feeds its A/B/Cin and consumes its Sum/Cout, so wide additions reuse a narrow adder.

---
 rtl/multiword_add_pkg.sv | 17 +
 rtl/multiword_add_seq_nbitadd.sv | 21 ++
 rtl/multiword_add_seq.sv | 112 +++++++++++
 tb/tb_multiword_add_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the word-serial multi-precision adder.
package multiword_add_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Word counter width; a single-word configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned words);
    if (words <= 1) begin
      return 1;
    end
    return $clog2(words);
  endfunction

endpackage

// File: rtl/multiword_add_seq_nbitadd.sv
// Combinational N-bit ripple adder: {Cout, Sum} = A + B + Cin.
module nbitAdd #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] total;

  always_comb begin
    total = {1'b0, A} + {1'b0, B} + (N+1)'(Cin);
  end

  assign Sum  = total[N-1:0];
  assign Cout = total[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial multi-precision adder: streams WORDS x WIDTH-bit operands LSW first,
// chaining the carry between beats around a single nbitAdd.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned    CW       = cnt_width(WORDS);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORDS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;

  logic             accept;
  logic             is_last;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // One-deep output register: a new beat may enter as the held one leaves.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_last  = (cnt_q == LAST_IDX);
  assign add_cin  = (cnt_q == '0) ? in_cin : carry_q;

  nbitAdd #(
    .N (WIDTH)
  ) u_add (
    .A    (a_word),
    .B    (b_word),
    .Cin  (add_cin),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_last_d  = is_last;
      out_cout_d  = is_last ? add_cout : 1'b0;
      if (is_last) begin
        // Clearing the carry on wrap keeps one operation from leaking into the next.
        cnt_d   = '0;
        carry_d = 1'b0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        carry_d = add_cout;
        state_d = RUN;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (WIDTH=4, WORDS=4): table of operations plus hand sequences.
module tb_multiword_add_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_word;
  logic [3:0] b_word;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       busy;

  multiword_add_seq #(
    .WIDTH (4),
    .WORDS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    int          gap_word;
    int          hold_word;
  } vec_t;

  typedef struct {
    logic [3:0] sum;
    logic       last;
    logic       cout;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_fail;

  logic [3:0] cur_sum;
  logic       cur_last;
  logic       cur_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge: score any output beat consumed at the coming edge, then log an accepted input.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_cout", 32'(out_cout), 32'(e.cout));
      end
    end
    acc = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst_n === 1'b1);
    if (acc) sb.push_back('{sum: cur_sum, last: cur_last, cout: cur_cout});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input vec_t v, input int w);
    in_valid = 1'b1;
    a_word   = v.a[4*w +: 4];
    b_word   = v.b[4*w +: 4];
    in_cin   = (w == 0) ? v.cin : ~v.cin;
    cur_sum  = v.sum[4*w +: 4];
    cur_last = (w == 3);
    cur_cout = (w == 3) ? v.cout : 1'b0;
  endtask

  task automatic send_op(input vec_t v);
    bit acc;
    int guard;
    for (int w = 0; w < 4; w++) begin
      if (w == v.gap_word) begin
        in_valid = 1'b0;
        repeat (2) begin
          step(acc);
          check("gap_busy", 32'(busy), 32'(1));
        end
      end
      drive_word(v, w);
      if (w == v.hold_word) begin
        out_ready = 1'b0;
        repeat (3) begin
          step(acc);
          check("hold_in_ready", 32'(in_ready), 32'(0));
          check("hold_out_valid", 32'(out_valid), 32'(1));
          check("hold_out_sum", 32'(out_sum), 32'(v.sum[4*(w-1) +: 4]));
        end
        out_ready = 1'b1;
      end
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 20) begin
        step(acc);
        guard++;
      end
      if (!acc) check("accept_timeout", 32'(0), 32'(1));
      check("latency_valid", 32'(out_valid), 32'(1));
      check("busy_after_beat", 32'(busy), 32'(w != 3));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int guard;
    in_valid = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && guard < 20) begin
      step(acc);
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  vec_t vecs[8];

  initial begin
    bit acc;
    vec_t r;
    n_vec     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_word    = '0;
    b_word    = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    cur_sum   = '0;
    cur_last  = 1'b0;
    cur_cout  = 1'b0;

    vecs[0] = '{a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0, gap_word: -1, hold_word: -1};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1, gap_word: -1, hold_word: -1};
    vecs[2] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, gap_word: -1, hold_word: -1};
    vecs[3] = '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sum: 16'h0002, cout: 1'b0, gap_word: -1, hold_word: -1};
    vecs[4] = '{a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0, gap_word: -1, hold_word: 1};
    vecs[5] = '{a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0, gap_word: 2, hold_word: -1};
    vecs[6] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, gap_word: -1, hold_word: -1};
    vecs[7] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b1, sum: 16'hBCDF, cout: 1'b0, gap_word: -1, hold_word: -1};

    step(acc);
    step(acc);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sum", 32'(out_sum), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_cout", 32'(out_cout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    step(acc);

    // Ops 2 and 3 run back to back with no idle cycle between them.
    for (int i = 0; i < 8; i++) begin
      send_op(vecs[i]);
      if (i != 2) drain();
    end

    // Reset after two accepted beats discards the partial operation.
    r = '{a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0, gap_word: -1, hold_word: -1};
    drive_word(r, 0);
    step(acc);
    check("rst_mid_acc0", 32'(acc), 32'(1));
    drive_word(r, 1);
    step(acc);
    check("rst_mid_acc1", 32'(acc), 32'(1));
    check("rst_mid_busy_pre", 32'(busy), 32'(1));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step(acc);
    rst_n = 1'b1;
    sb.delete();
    check("rst_mid_out_valid", 32'(out_valid), 32'(0));
    check("rst_mid_out_sum", 32'(out_sum), 32'(0));
    check("rst_mid_out_last", 32'(out_last), 32'(0));
    check("rst_mid_out_cout", 32'(out_cout), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    r = '{a: 16'h0001, b: 16'h0002, cin: 1'b1, sum: 16'h0004, cout: 1'b0, gap_word: -1, hold_word: -1};
    send_op(r);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
